// File: rtl/ram_arb_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : ram_arb_pkg
//  Purpose  : Shared definitions for the RAM arbiter slice: FSM state
//             encoding, requester IDs and default bus widths.
//  Contents : arb_state_t  - IDLE / ACCESS / CAPTURE / RESP
//             REQ_*        - requester IDs, also used as the grant code
//             *_W_DEF      - default address / data widths
//  Revision : 1.0 - initial release
// ============================================================================
package ram_arb_pkg;

    localparam int ADDR_W_DEF = 16;
    localparam int DATA_W_DEF = 8;

    // Requester IDs double as bit positions in the packed request vector
    // {s5, s3, s12} and as the value driven on the grant debug output.
    localparam logic [1:0] REQ_S12  = 2'd0;
    localparam logic [1:0] REQ_S3   = 2'd1;
    localparam logic [1:0] REQ_S5   = 2'd2;
    localparam logic [1:0] REQ_NONE = 2'd3;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        ACCESS  = 2'd1,
        CAPTURE = 2'd2,
        RESP    = 2'd3
    } arb_state_t;

endpackage : ram_arb_pkg
`default_nettype wire

// File: rtl/ram_arbiter_if.sv
`default_nettype none
// ============================================================================
//  Module   : ram_arbiter_if
//  Purpose  : Bundles the three requester handshakes and the RAM-side bus
//             of the arbiter.
//  Modports : slave  - arbiter view (reqs in, readies/rdata/RAM controls out)
//             master - pipeline/RAM environment view
//  Signals  : s12_*/s3_* read ports, s5_* write port, ram_* RAM bus,
//             grant debug owner code
//  Revision : 1.0 - initial release
// ============================================================================
interface ram_arbiter_if
    import ram_arb_pkg::*;
#(
    parameter int ADDR_W = ADDR_W_DEF,
    parameter int DATA_W = DATA_W_DEF
);
    logic              s12_req;
    logic [ADDR_W-1:0] s12_addr;
    logic              s12_ready;
    logic [DATA_W-1:0] s12_rdata;

    logic              s3_req;
    logic [ADDR_W-1:0] s3_addr;
    logic              s3_ready;
    logic [DATA_W-1:0] s3_rdata;

    logic              s5_req;
    logic [ADDR_W-1:0] s5_addr;
    logic [DATA_W-1:0] s5_wdata;
    logic              s5_ready;

    logic              ram_write_enable;
    logic [ADDR_W-1:0] ram_address;
    logic [DATA_W-1:0] ram_data_in;
    logic [DATA_W-1:0] ram_data_out;

    logic [1:0]        grant;

    modport slave (
        input  s12_req, s12_addr, s3_req, s3_addr,
        input  s5_req, s5_addr, s5_wdata, ram_data_out,
        output s12_ready, s12_rdata, s3_ready, s3_rdata, s5_ready,
        output ram_write_enable, ram_address, ram_data_in, grant
    );

    modport master (
        output s12_req, s12_addr, s3_req, s3_addr,
        output s5_req, s5_addr, s5_wdata, ram_data_out,
        input  s12_ready, s12_rdata, s3_ready, s3_rdata, s5_ready,
        input  ram_write_enable, ram_address, ram_data_in, grant
    );

endinterface : ram_arbiter_if
`default_nettype wire

// File: rtl/ram_arb_pick.sv
`default_nettype none
// ============================================================================
//  Module   : ram_arb_pick
//  Purpose  : Combinational winner selection among the three requesters.
//  Ports    : i_req    [2:0] request bits, index = requester ID
//             i_last   [1:0] last granted requester (RR pointer)
//             o_winner [1:0] winning requester ID, REQ_NONE if no request
//  Config   : RAM_ARBITER_RR_EN defined   -> round robin starting after
//                                            i_last, order s12 -> s3 -> s5
//             RAM_ARBITER_RR_EN undefined -> fixed priority s3 > s12 > s5,
//                                            i_last ignored
//  Revision : 1.0 - initial release
// ============================================================================
module ram_arb_pick
    import ram_arb_pkg::*;
(
    input  wire logic [2:0] i_req,
    input  wire logic [1:0] i_last,
    output logic      [1:0] o_winner
);

`ifdef RAM_ARBITER_RR_EN
    always_comb begin
        o_winner = REQ_NONE;
        case (i_last)
            REQ_S12: begin
                if      (i_req[REQ_S3])  o_winner = REQ_S3;
                else if (i_req[REQ_S5])  o_winner = REQ_S5;
                else if (i_req[REQ_S12]) o_winner = REQ_S12;
            end
            REQ_S3: begin
                if      (i_req[REQ_S5])  o_winner = REQ_S5;
                else if (i_req[REQ_S12]) o_winner = REQ_S12;
                else if (i_req[REQ_S3])  o_winner = REQ_S3;
            end
            // REQ_S5 and the unused code 3 both restart the search at s12.
            default: begin
                if      (i_req[REQ_S12]) o_winner = REQ_S12;
                else if (i_req[REQ_S3])  o_winner = REQ_S3;
                else if (i_req[REQ_S5])  o_winner = REQ_S5;
            end
        endcase
    end
`else
    // The pointer has no meaning under fixed priority.
    logic w_unused_last;
    assign w_unused_last = ^i_last;

    always_comb begin
        o_winner = REQ_NONE;
        if      (i_req[REQ_S3])  o_winner = REQ_S3;
        else if (i_req[REQ_S12]) o_winner = REQ_S12;
        else if (i_req[REQ_S5])  o_winner = REQ_S5;
    end
`endif

endmodule : ram_arb_pick
`default_nettype wire

// File: rtl/ram_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : ram_arbiter
//  Purpose  : Shares one synchronous single-port RAM between the stage12
//             (read), stage3 (read) and stage5 (write) requesters using a
//             fixed 4-cycle IDLE -> ACCESS -> CAPTURE -> RESP handshake.
//  Ports    : ram_clk - clock, all logic on the rising edge
//             rst     - synchronous active-high reset
//             bus     - ram_arbiter_if.slave: requester req/addr/ready/rdata,
//                       s5 write data, RAM address/we/data, grant debug
//  Config   : RAM_ARBITER_RR_EN - round-robin arbitration with a last-grant
//             pointer; default build is fixed priority s3 > s12 > s5
//  Revision : 1.0 - initial release
// ============================================================================
module ram_arbiter
    import ram_arb_pkg::*;
#(
    parameter int ADDR_W = ADDR_W_DEF,
    parameter int DATA_W = DATA_W_DEF
) (
    input  wire logic     ram_clk,
    input  wire logic     rst,
    ram_arbiter_if.slave  bus
);

    arb_state_t        r_state;
    logic [1:0]        r_grant;
    logic              r_s12_ready;
    logic              r_s3_ready;
    logic              r_s5_ready;
    logic [DATA_W-1:0] r_s12_rdata;
    logic [DATA_W-1:0] r_s3_rdata;
    logic              r_ram_write_enable;
    logic [ADDR_W-1:0] r_ram_address;
    logic [DATA_W-1:0] r_ram_data_in;

    logic [2:0]        w_req;
    logic [1:0]        w_last;
    logic [1:0]        w_winner;

    assign w_req = {bus.s5_req, bus.s3_req, bus.s12_req};

`ifdef RAM_ARBITER_RR_EN
    logic [1:0] r_last;
    assign w_last = r_last;
`else
    assign w_last = REQ_S5;
`endif

    ram_arb_pick u_pick (
        .i_req    (w_req),
        .i_last   (w_last),
        .o_winner (w_winner)
    );

    always_ff @(posedge ram_clk) begin
        if (rst) begin
            r_state            <= IDLE;
            r_grant            <= REQ_NONE;
            r_s12_ready        <= 1'b0;
            r_s3_ready         <= 1'b0;
            r_s5_ready         <= 1'b0;
            r_s12_rdata        <= '0;
            r_s3_rdata         <= '0;
            r_ram_write_enable <= 1'b0;
            r_ram_address      <= '0;
            r_ram_data_in      <= '0;
`ifdef RAM_ARBITER_RR_EN
            r_last             <= REQ_S5;
`endif
        end else begin
            case (r_state)
                IDLE: begin
                    if (|w_req) begin
                        // Address and write data are captured here, so the
                        // requester may change them freely after the grant.
                        r_grant            <= w_winner;
                        r_state            <= ACCESS;
                        r_ram_write_enable <= (w_winner == REQ_S5);
`ifdef RAM_ARBITER_RR_EN
                        r_last             <= w_winner;
`endif
                        case (w_winner)
                            REQ_S12: r_ram_address <= bus.s12_addr;
                            REQ_S3:  r_ram_address <= bus.s3_addr;
                            REQ_S5: begin
                                r_ram_address <= bus.s5_addr;
                                r_ram_data_in <= bus.s5_wdata;
                            end
                            default: ;
                        endcase
                    end else begin
                        r_grant <= REQ_NONE;
                    end
                end

                ACCESS: begin
                    // The RAM samples address/we on the edge that ends this
                    // cycle, so write enable is high for exactly one cycle.
                    r_ram_write_enable <= 1'b0;
                    r_state            <= CAPTURE;
                end

                CAPTURE: begin
                    case (r_grant)
                        REQ_S12: begin
                            r_s12_rdata <= bus.ram_data_out;
                            r_s12_ready <= 1'b1;
                        end
                        REQ_S3: begin
                            r_s3_rdata <= bus.ram_data_out;
                            r_s3_ready <= 1'b1;
                        end
                        REQ_S5:  r_s5_ready <= 1'b1;
                        default: ;
                    endcase
                    r_state <= RESP;
                end

                RESP: begin
                    // Requests are not sampled here; this gives the served
                    // port one edge to drop its req before IDLE looks again.
                    r_s12_ready <= 1'b0;
                    r_s3_ready  <= 1'b0;
                    r_s5_ready  <= 1'b0;
                    r_grant     <= REQ_NONE;
                    r_state     <= IDLE;
                end

                default: r_state <= IDLE;
            endcase
        end
    end

    assign bus.grant            = r_grant;
    assign bus.s12_ready        = r_s12_ready;
    assign bus.s12_rdata        = r_s12_rdata;
    assign bus.s3_ready         = r_s3_ready;
    assign bus.s3_rdata         = r_s3_rdata;
    assign bus.s5_ready         = r_s5_ready;
    assign bus.ram_write_enable = r_ram_write_enable;
    assign bus.ram_address      = r_ram_address;
    assign bus.ram_data_in      = r_ram_data_in;

endmodule : ram_arbiter
`default_nettype wire

// File: tb/tb_ram_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : tb_ram_arbiter
//  Purpose  : Self-checking bench for ram_arbiter with a 64Kx8 synchronous
//             RAM model and a queue of expected responses.
//  Config   : RAM_ARBITER_RR_EN selects the round-robin expectations.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_ram_arbiter;
    import ram_arb_pkg::*;

    logic ram_clk = 1'b0;
    logic rst;

    always #5 ram_clk = ~ram_clk;

    ram_arbiter_if #(.ADDR_W(16), .DATA_W(8)) bus ();

    ram_arbiter #(.ADDR_W(16), .DATA_W(8)) u_dut (
        .ram_clk (ram_clk),
        .rst     (rst),
        .bus     (bus.slave)
    );

    // RAM model: read-first synchronous RAM plus a bench-only preload port.
    logic [7:0]  mem [0:65535];
    logic        pl_we;
    logic [15:0] pl_addr;
    logic [7:0]  pl_data;

    always @(posedge ram_clk) begin
        if (pl_we)
            mem[pl_addr] <= pl_data;
        else if (bus.ram_write_enable)
            mem[bus.ram_address] <= bus.ram_data_in;
        bus.ram_data_out <= mem[bus.ram_address];
    end

    // Reference contents, maintained only from the stimulus side.
    logic [7:0] ref_mem [0:65535];

    typedef struct {
        int         port;
        logic [7:0] data;
    } exp_t;

    exp_t sb[$];
    int   n_checks = 0;
    int   n_fail   = 0;

    task automatic preload(input logic [15:0] a, input logic [7:0] d);
        pl_we   = 1'b1;
        pl_addr = a;
        pl_data = d;
        ref_mem[a] = d;
        @(negedge ram_clk);
        pl_we = 1'b0;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        repeat (2) @(negedge ram_clk);
        rst = 1'b0;
    endtask

    // Waits up to max_edges rising edges for any ready; port = -1 on timeout.
    task automatic wait_ready(input int max_edges, output int port, output int edges);
        port  = -1;
        edges = 0;
        while (edges < max_edges) begin
            @(negedge ram_clk);
            edges++;
            if (bus.s12_ready) begin port = 0; break; end
            if (bus.s3_ready)  begin port = 1; break; end
            if (bus.s5_ready)  begin port = 2; break; end
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (2) @(negedge ram_clk);
        n_checks++;
        if (bus.grant !== 2'd3) begin
            n_fail++;
            $display("FAIL reset_grant: got %0d expected 3", bus.grant);
        end
        n_checks++;
        if ({bus.s12_ready, bus.s3_ready, bus.s5_ready, bus.ram_write_enable} !== 4'b0000) begin
            n_fail++;
            $display("FAIL reset_flags: got %b expected 0000",
                     {bus.s12_ready, bus.s3_ready, bus.s5_ready, bus.ram_write_enable});
        end
        n_checks++;
        if ({bus.ram_address, bus.ram_data_in, bus.s12_rdata, bus.s3_rdata} !== 40'd0) begin
            n_fail++;
            $display("FAIL reset_data: got addr=%h din=%h r12=%h r3=%h expected all zero",
                     bus.ram_address, bus.ram_data_in, bus.s12_rdata, bus.s3_rdata);
        end
        rst = 1'b0;
        @(negedge ram_clk);
    endtask

    task automatic test_single_read();
        exp_t e;
        sb.push_back('{port: 0, data: ref_mem[16'h0004]});
        bus.s12_addr = 16'h0004;
        bus.s12_req  = 1'b1;
        @(negedge ram_clk);  // after E0
        n_checks++;
        if (bus.grant !== 2'd0 || bus.ram_address !== 16'h0004 || bus.ram_write_enable !== 1'b0
            || bus.s12_ready !== 1'b0) begin
            n_fail++;
            $display("FAIL read_e0: got grant=%0d addr=%h we=%b rdy=%b expected 0 0004 0 0",
                     bus.grant, bus.ram_address, bus.ram_write_enable, bus.s12_ready);
        end
        @(negedge ram_clk);  // after E1
        n_checks++;
        if (bus.grant !== 2'd0 || bus.s12_ready !== 1'b0) begin
            n_fail++;
            $display("FAIL read_e1: got grant=%0d rdy=%b expected 0 0", bus.grant, bus.s12_ready);
        end
        @(negedge ram_clk);  // after E2
        e = sb.pop_front();
        n_checks++;
        if (bus.s12_ready !== 1'b1 || bus.grant !== 2'd0) begin
            n_fail++;
            $display("FAIL read_e2_ready: got rdy=%b grant=%0d expected 1 0", bus.s12_ready, bus.grant);
        end
        n_checks++;
        if (bus.s12_rdata !== e.data) begin
            n_fail++;
            $display("FAIL read_data: got %h expected %h", bus.s12_rdata, e.data);
        end
        bus.s12_req = 1'b0;
        @(negedge ram_clk);  // after E3
        n_checks++;
        if (bus.s12_ready !== 1'b0 || bus.grant !== 2'd3) begin
            n_fail++;
            $display("FAIL read_e3: got rdy=%b grant=%0d expected 0 3", bus.s12_ready, bus.grant);
        end
    endtask

    task automatic test_write_then_read(input logic [15:0] a, input logic [7:0] d);
        exp_t e;
        int   p;
        int   n;
        ref_mem[a] = d;
        sb.push_back('{port: 2, data: d});
        bus.s5_addr  = a;
        bus.s5_wdata = d;
        bus.s5_req   = 1'b1;
        @(negedge ram_clk);  // after E0
        n_checks++;
        if (bus.ram_write_enable !== 1'b1 || bus.ram_address !== a || bus.ram_data_in !== d
            || bus.grant !== 2'd2) begin
            n_fail++;
            $display("FAIL write_e0: got we=%b addr=%h din=%h grant=%0d expected 1 %h %h 2",
                     bus.ram_write_enable, bus.ram_address, bus.ram_data_in, bus.grant, a, d);
        end
        @(negedge ram_clk);  // after E1
        n_checks++;
        if (bus.ram_write_enable !== 1'b0) begin
            n_fail++;
            $display("FAIL write_we_len: got we=%b after E1 expected 0", bus.ram_write_enable);
        end
        @(negedge ram_clk);  // after E2
        e = sb.pop_front();
        n_checks++;
        if (bus.s5_ready !== 1'b1 || e.port !== 2) begin
            n_fail++;
            $display("FAIL write_ready: got rdy=%b expected 1", bus.s5_ready);
        end
        bus.s5_req = 1'b0;
        @(negedge ram_clk);  // after E3, back in IDLE
        sb.push_back('{port: 1, data: ref_mem[a]});
        bus.s3_addr = a;
        bus.s3_req  = 1'b1;
        wait_ready(8, p, n);
        e = sb.pop_front();
        n_checks++;
        if (p !== e.port || n !== 3) begin
            n_fail++;
            $display("FAIL readback_timing: got port=%0d edges=%0d expected port=%0d edges=3", p, n, e.port);
        end
        n_checks++;
        if (bus.s3_rdata !== e.data) begin
            n_fail++;
            $display("FAIL readback_data: got %h expected %h", bus.s3_rdata, e.data);
        end
        bus.s3_req = 1'b0;
        repeat (2) @(negedge ram_clk);
    endtask

    task automatic test_contention();
        exp_t e;
        int   p;
        int   n;
        int   total;
        int   n_grants;
        do_reset();
        ref_mem[16'h0200] = 8'h77;
`ifdef RAM_ARBITER_RR_EN
        n_grants = 4;
        sb.push_back('{port: 0, data: ref_mem[16'h0004]});
        sb.push_back('{port: 1, data: ref_mem[16'h0010]});
        sb.push_back('{port: 2, data: 8'h77});
        sb.push_back('{port: 0, data: ref_mem[16'h0004]});
`else
        n_grants = 3;
        sb.push_back('{port: 1, data: ref_mem[16'h0010]});
        sb.push_back('{port: 0, data: ref_mem[16'h0004]});
        sb.push_back('{port: 2, data: 8'h77});
`endif
        bus.s12_addr = 16'h0004;
        bus.s3_addr  = 16'h0010;
        bus.s5_addr  = 16'h0200;
        bus.s5_wdata = 8'h77;
        bus.s12_req  = 1'b1;
        bus.s3_req   = 1'b1;
        bus.s5_req   = 1'b1;
        total = 0;
        for (int i = 0; i < n_grants; i++) begin
            wait_ready(8, p, n);
            total += n;
            e = sb.pop_front();
            n_checks++;
            if (p !== e.port || total !== 3 + 4 * i) begin
                n_fail++;
                $display("FAIL contention_order[%0d]: got port=%0d at edge %0d expected port=%0d at edge %0d",
                         i, p, total, e.port, 3 + 4 * i);
            end
            n_checks++;
            if (32'(bus.s12_ready) + 32'(bus.s3_ready) + 32'(bus.s5_ready) !== 32'd1) begin
                n_fail++;
                $display("FAIL contention_onehot[%0d]: got readies=%b%b%b expected exactly one",
                         i, bus.s12_ready, bus.s3_ready, bus.s5_ready);
            end
            if (p == 0 || p == 1) begin
                n_checks++;
                if ((p == 0 ? bus.s12_rdata : bus.s3_rdata) !== e.data) begin
                    n_fail++;
                    $display("FAIL contention_data[%0d]: got %h expected %h", i,
                             (p == 0 ? bus.s12_rdata : bus.s3_rdata), e.data);
                end
            end
`ifndef RAM_ARBITER_RR_EN
            if (p == 0) bus.s12_req = 1'b0;
            if (p == 1) bus.s3_req  = 1'b0;
            if (p == 2) bus.s5_req  = 1'b0;
`endif
        end
        bus.s12_req = 1'b0;
        bus.s3_req  = 1'b0;
        bus.s5_req  = 1'b0;
        repeat (2) @(negedge ram_clk);
    endtask

    task automatic test_reset_mid_access();
        exp_t e;
        int   p;
        int   n;
        bus.s12_addr = 16'h0004;
        bus.s12_req  = 1'b1;
        repeat (2) @(negedge ram_clk);  // after E1, FSM in CAPTURE
        rst = 1'b1;
        @(negedge ram_clk);             // reset taken at E2
        n_checks++;
        if (bus.s12_ready !== 1'b0 || bus.grant !== 2'd3 || bus.ram_write_enable !== 1'b0) begin
            n_fail++;
            $display("FAIL abort_ctrl: got rdy=%b grant=%0d we=%b expected 0 3 0",
                     bus.s12_ready, bus.grant, bus.ram_write_enable);
        end
        n_checks++;
        if ({bus.ram_address, bus.ram_data_in, bus.s12_rdata, bus.s3_rdata} !== 40'd0) begin
            n_fail++;
            $display("FAIL abort_data: got addr=%h din=%h r12=%h r3=%h expected all zero",
                     bus.ram_address, bus.ram_data_in, bus.s12_rdata, bus.s3_rdata);
        end
        rst = 1'b0;
        sb.push_back('{port: 0, data: ref_mem[16'h0004]});
        wait_ready(8, p, n);
        e = sb.pop_front();
        n_checks++;
        if (p !== e.port || n !== 3 || bus.s12_rdata !== e.data) begin
            n_fail++;
            $display("FAIL after_abort: got port=%0d edges=%0d data=%h expected port=0 edges=3 data=%h",
                     p, n, bus.s12_rdata, e.data);
        end
        bus.s12_req = 1'b0;
        repeat (2) @(negedge ram_clk);
    endtask

    task automatic test_addr_change();
        exp_t e;
        int   p;
        int   n;
        sb.push_back('{port: 0, data: ref_mem[16'h0010]});
        bus.s12_addr = 16'h0010;
        bus.s12_req  = 1'b1;
        @(negedge ram_clk);             // after grant edge
        bus.s12_addr = 16'h0020;
        wait_ready(8, p, n);
        e = sb.pop_front();
        n_checks++;
        if (p !== e.port || n !== 2 || bus.s12_rdata !== e.data) begin
            n_fail++;
            $display("FAIL addr_latch: got port=%0d edges=%0d data=%h expected port=0 edges=2 data=%h",
                     p, n, bus.s12_rdata, e.data);
        end
        bus.s12_req = 1'b0;
        repeat (2) @(negedge ram_clk);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst          = 1'b1;
        pl_we        = 1'b0;
        pl_addr      = '0;
        pl_data      = '0;
        bus.s12_req  = 1'b0;
        bus.s12_addr = '0;
        bus.s3_req   = 1'b0;
        bus.s3_addr  = '0;
        bus.s5_req   = 1'b0;
        bus.s5_addr  = '0;
        bus.s5_wdata = '0;

        test_reset();
        preload(16'h0004, 8'hA5);
        preload(16'h0010, 8'h11);
        preload(16'h0020, 8'h22);
        @(negedge ram_clk);

        test_single_read();
        test_write_then_read(16'h0100, 8'h3C);
        test_write_then_read(16'hFFFF, 8'h5A);
        test_contention();
        test_reset_mid_access();
        test_addr_change();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule : tb_ram_arbiter
`default_nettype wire
